multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/ctrl_pkg.sv | 110 +++++++++++
 rtl/mul_sequencer.sv | 72 +++++++
 rtl/multicycle_control_unit.sv | 100 ++++++++++
 tb/tb_multicycle_control_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants, encodings and decode helpers
// for the multicycle control unit.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_MUL    = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_R      = 3'd2,
    ALU_MUL    = 3'd3,
    ALU_PASS_B = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    branch;
    logic    jump;
    logic    mem_read;
    logic    mem_write;
    logic    mem_2_reg;
    logic    alu_src;
    logic    reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op:    ALU_ADD,
    branch:    1'b0,
    jump:      1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    mem_2_reg: 1'b0,
    alu_src:   1'b0,
    reg_write: 1'b0
  };

  function automatic logic is_legal(
    input logic [6:0] op
  );
    return (op == OP_R)      ||
           (op == OP_I)      ||
           (op == OP_LOAD)   ||
           (op == OP_STORE)  ||
           (op == OP_BRANCH) ||
           (op == OP_JAL)    ||
           (op == OP_LUI);
  endfunction

  function automatic ctrl_t decode(
    input logic [6:0] op,
    input logic [6:0] f7
  );
    ctrl_t c;
    c = CTRL_NOP;
    unique case (1'b1)
      (op == OP_R): begin
        if (f7 == F7_MUL) begin
          c.alu_op = ALU_MUL;
        end else begin
          c.alu_op    = ALU_R;
          c.reg_write = 1'b1;
        end
      end
      (op == OP_I): begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      (op == OP_LOAD): begin
        c.alu_src   = 1'b1;
        c.mem_read  = 1'b1;
        c.mem_2_reg = 1'b1;
        c.reg_write = 1'b1;
      end
      (op == OP_STORE): begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      (op == OP_BRANCH): begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      (op == OP_JAL): begin
        c.jump   = 1'b1;
        c.alu_op = ALU_SUB;
      end
      (op == OP_LUI): begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_PASS_B;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Multiply latency sequencer: launches, counts
// down stall cycles and strobes writeback.
module mul_sequencer
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_mul_req,
  input  logic       i_flush,
  output mul_state_e o_state,
  output logic       o_mul_start,
  output logic       o_mul_done,
  output logic       o_stall
);

  mul_state_e r_state;
  logic [3:0] r_cnt;
  logic       w_launch;

  assign w_launch    = (r_state == ST_IDLE) &&
                       i_mul_req && !i_flush;
  assign o_state     = r_state;
  assign o_mul_start = w_launch;
  assign o_stall     = w_launch ||
                       (r_state == ST_BUSY);
  assign o_mul_done  = (r_state == ST_DONE) &&
                       !i_flush;

  // State and latency counter; flush aborts to idle
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            if (MUL_LATENCY == 1) begin
              r_state <= ST_DONE;
              r_cnt   <= 4'd0;
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= 4'(MUL_LATENCY - 1);
            end
          end
        end
        ST_BUSY: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt <= 4'd1) begin
            r_state <= ST_DONE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Decode-stage control unit with a multi-cycle
// multiply sequencer and sticky illegal flag.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int ALU_OP_W    = 3
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                valid_in,
  input  logic                flush,
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                branch,
  output logic                jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_2_reg,
  output logic                alu_src,
  output logic                reg_write,
  output logic                mul_start,
  output logic                mul_done,
  output logic                stall,
  output logic                illegal_op
);

  mul_state_e w_state;
  ctrl_t      w_dec;
  ctrl_t      w_ctrl;
  logic       w_legal;
  logic       w_mul_req;
  logic       r_illegal;

  assign w_dec     = decode(opcode, funct7);
  assign w_legal   = is_legal(opcode);
  assign w_mul_req = valid_in &&
                     (opcode == OP_R) &&
                     (funct7 == F7_MUL);

  mul_sequencer #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_seq (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_mul_req   (w_mul_req),
    .i_flush     (flush),
    .o_state     (w_state),
    .o_mul_start (mul_start),
    .o_mul_done  (mul_done),
    .o_stall     (stall)
  );

  // Only idle decodes; busy/done show the multiply
  always_comb begin
    w_ctrl = CTRL_NOP;
    unique case (w_state)
      ST_IDLE: begin
        if (valid_in) begin
          w_ctrl = w_dec;
          if (flush) begin
            w_ctrl.reg_write = 1'b0;
            w_ctrl.mem_write = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        w_ctrl.alu_op = ALU_MUL;
      end
      ST_DONE: begin
        w_ctrl.alu_op    = ALU_MUL;
        w_ctrl.reg_write = !flush;
      end
      default: w_ctrl = CTRL_NOP;
    endcase
  end

  assign alu_op    = ALU_OP_W'(w_ctrl.alu_op);
  assign branch    = w_ctrl.branch;
  assign jump      = w_ctrl.jump;
  assign mem_read  = w_ctrl.mem_read;
  assign mem_write = w_ctrl.mem_write;
  assign mem_2_reg = w_ctrl.mem_2_reg;
  assign alu_src   = w_ctrl.alu_src;
  assign reg_write = w_ctrl.reg_write;

  // Sticky flag for undecodable opcodes issued in idle
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_illegal <= 1'b0;
    end else if ((w_state == ST_IDLE) && valid_in &&
                 !flush && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: decode table plus
// multiply, flush, illegal and reset sequences.
module tb_multicycle_control_unit;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [6:0] MF  = 7'b0000001;

  logic       clk = 1'b0;
  logic       arst_n, valid_in, flush;
  logic [6:0] opcode, funct7;

  logic [2:0] alu0;
  logic br0, jp0, mr0, mw0, m2r0, as0, rw0;
  logic ms0, md0, st0, il0;
  logic [3:0] alu1;
  logic br1, jp1, mr1, mw1, m2r1, as1, rw1;
  logic ms1, md1, st1, il1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    bit         sel;
    logic [14:0] exp;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string      nm;
    logic       v;
    logic       f;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] alu;
    logic [6:0] ctl;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .valid_in   (valid_in),
    .flush      (flush),
    .opcode     (opcode),
    .funct7     (funct7),
    .alu_op     (alu0),
    .branch     (br0),
    .jump       (jp0),
    .mem_read   (mr0),
    .mem_write  (mw0),
    .mem_2_reg  (m2r0),
    .alu_src    (as0),
    .reg_write  (rw0),
    .mul_start  (ms0),
    .mul_done   (md0),
    .stall      (st0),
    .illegal_op (il0)
  );

  multicycle_control_unit #(
    .MUL_LATENCY (1),
    .ALU_OP_W    (4)
  ) dut1 (
    .clk        (clk),
    .arst_n     (arst_n),
    .valid_in   (valid_in),
    .flush      (flush),
    .opcode     (opcode),
    .funct7     (funct7),
    .alu_op     (alu1),
    .branch     (br1),
    .jump       (jp1),
    .mem_read   (mr1),
    .mem_write  (mw1),
    .mem_2_reg  (m2r1),
    .alu_src    (as1),
    .reg_write  (rw1),
    .mul_start  (ms1),
    .mul_done   (md1),
    .stall      (st1),
    .illegal_op (il1)
  );

  wire [14:0] out0 = {1'b0, alu0, br0, jp0, mr0,
                      mw0, m2r0, as0, rw0,
                      ms0, md0, st0, il0};
  wire [14:0] out1 = {alu1, br1, jp1, mr1,
                      mw1, m2r1, as1, rw1,
                      ms1, md1, st1, il1};

  function automatic logic [14:0] E(
    input logic [3:0] a,
    input logic [6:0] c,
    input logic ms, md, sl, il
  );
    return {a, c, ms, md, sl, il};
  endfunction

  task automatic drv(
    input logic rn, v, f,
    input logic [6:0] op, f7
  );
    @(negedge clk);
    arst_n   = rn;
    valid_in = v;
    flush    = f;
    opcode   = op;
    funct7   = f7;
  endtask

  task automatic ex(
    input string nm,
    input bit sel,
    input logic [14:0] e
  );
    sbq.push_back('{nm: nm, sel: sel, exp: e});
  endtask

  task automatic settle();
    exp_t e;
    logic [14:0] g;
    #1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      g = e.sel ? out1 : out0;
      checks++;
      if (g !== e.exp) begin
        errors++;
        $display("FAIL %s got=%b exp=%b",
                 e.nm, g, e.exp);
      end
    end
  endtask

  task automatic rst();
    drv(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
  endtask

  task automatic idle_chk(input string nm);
    drv(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
    ex({nm, "/l4"}, 1'b0, E(0, 0, 0, 0, 0, 0));
    ex({nm, "/l1"}, 1'b1, E(0, 0, 0, 0, 0, 0));
    settle();
  endtask

  initial begin
    tbl[0]  = '{"add",   1, 0, R,   7'h00, 3'd2, 7'b0000001};
    tbl[1]  = '{"sub",   1, 0, R,   7'h20, 3'd2, 7'b0000001};
    tbl[2]  = '{"addi",  1, 0, I,   7'h00, 3'd0, 7'b0000011};
    tbl[3]  = '{"load",  1, 0, LD,  7'h00, 3'd0, 7'b0010111};
    tbl[4]  = '{"store", 1, 0, ST,  7'h00, 3'd0, 7'b0001010};
    tbl[5]  = '{"beq",   1, 0, BR,  7'h00, 3'd1, 7'b1000000};
    tbl[6]  = '{"jal",   1, 0, JL,  7'h00, 3'd1, 7'b0100000};
    tbl[7]  = '{"lui",   1, 0, LU,  7'h00, 3'd4, 7'b0000011};
    tbl[8]  = '{"nv_ld", 0, 0, LD,  7'h00, 3'd0, 7'b0000000};
    tbl[9]  = '{"nv_bad",0, 0, BAD, 7'h00, 3'd0, 7'b0000000};
    tbl[10] = '{"fl_ld", 1, 1, LD,  7'h00, 3'd0, 7'b0010110};
    tbl[11] = '{"fl_st", 1, 1, ST,  7'h00, 3'd0, 7'b0000010};
    tbl[12] = '{"fl_mul",1, 1, R,   MF,    3'd3, 7'b0000000};
    tbl[13] = '{"fl_bad",1, 1, BAD, 7'h00, 3'd0, 7'b0000000};
    tbl[14] = '{"add2",  1, 0, R,   7'h00, 3'd2, 7'b0000001};

    rst();
    idle_chk("reset");

    for (int i = 0; i < 15; i++) begin
      drv(1'b1, tbl[i].v, tbl[i].f,
          tbl[i].op, tbl[i].f7);
      ex({tbl[i].nm, "/l4"}, 1'b0,
         E({1'b0, tbl[i].alu}, tbl[i].ctl,
           0, 0, 0, 0));
      ex({tbl[i].nm, "/l1"}, 1'b1,
         E({1'b0, tbl[i].alu}, tbl[i].ctl,
           0, 0, 0, 0));
      settle();
    end

    rst();
    drv(1, 1, 0, R, MF);
    ex("l4_t0", 0, E(3, 0, 1, 0, 1, 0)); settle();
    drv(1, 1, 0, LD, 0);
    ex("l4_t1", 0, E(3, 0, 0, 0, 1, 0)); settle();
    drv(1, 1, 0, R, MF);
    ex("l4_t2", 0, E(3, 0, 0, 0, 1, 0)); settle();
    drv(1, 1, 0, ST, 0);
    ex("l4_t3", 0, E(3, 0, 0, 0, 1, 0)); settle();
    drv(1, 1, 0, LD, 0);
    ex("l4_t4", 0, E(3, 7'b0000001, 0, 1, 0, 0));
    settle();
    drv(1, 1, 0, LD, 0);
    ex("l4_t5", 0, E(0, 7'b0010111, 0, 0, 0, 0));
    settle();

    rst();
    drv(1, 1, 0, R, MF);
    ex("l1_t0", 1, E(3, 0, 1, 0, 1, 0)); settle();
    drv(1, 0, 0, 0, 0);
    ex("l1_t1", 1, E(3, 7'b0000001, 0, 1, 0, 0));
    settle();
    drv(1, 1, 0, R, MF);
    ex("l1_b2b", 1, E(3, 0, 1, 0, 1, 0)); settle();
    drv(1, 0, 1, 0, 0);
    ex("l1_fl_done", 1, E(3, 0, 0, 0, 0, 0));
    settle();
    drv(1, 0, 0, 0, 0);
    ex("l1_after", 1, E(0, 0, 0, 0, 0, 0)); settle();

    rst();
    drv(1, 1, 0, R, MF);
    ex("fl_t0", 0, E(3, 0, 1, 0, 1, 0)); settle();
    drv(1, 0, 0, 0, 0);
    ex("fl_t1", 0, E(3, 0, 0, 0, 1, 0)); settle();
    drv(1, 0, 1, 0, 0);
    ex("fl_t2", 0, E(3, 0, 0, 0, 1, 0)); settle();
    for (int i = 3; i < 6; i++) begin
      drv(1, 0, 0, 0, 0);
      ex($sformatf("fl_t%0d", i), 0,
         E(0, 0, 0, 0, 0, 0));
      settle();
    end

    rst();
    drv(1, 1, 1, R, MF);
    ex("flmul/l4", 0, E(3, 0, 0, 0, 0, 0));
    ex("flmul/l1", 1, E(3, 0, 0, 0, 0, 0));
    settle();
    idle_chk("flmul_next");

    rst();
    drv(1, 1, 1, BAD, 0);
    ex("ill_fl", 0, E(0, 0, 0, 0, 0, 0)); settle();
    idle_chk("ill_fl_next");
    drv(1, 1, 0, BAD, 0);
    ex("ill_t0", 0, E(0, 0, 0, 0, 0, 0)); settle();
    drv(1, 0, 0, 0, 0);
    ex("ill_t1/l4", 0, E(0, 0, 0, 0, 0, 1));
    ex("ill_t1/l1", 1, E(0, 0, 0, 0, 0, 1));
    settle();
    drv(1, 1, 0, LD, 0);
    ex("ill_hold", 0, E(0, 7'b0010111, 0, 0, 0, 1));
    settle();
    drv(1, 1, 0, R, MF);
    ex("ill_mul", 0, E(3, 0, 1, 0, 1, 1)); settle();
    rst();
    idle_chk("ill_clr");

    rst();
    drv(1, 1, 0, R, MF);
    ex("rb_t0", 0, E(3, 0, 1, 0, 1, 0)); settle();
    drv(1, 0, 0, 0, 0);
    ex("rb_t1", 0, E(3, 0, 0, 0, 1, 0)); settle();
    rst();
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 0, 0, 0);
      ex($sformatf("rb_post%0d", i), 0,
         E(0, 0, 0, 0, 0, 0));
      settle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
